sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//   Serial-in, parallel-out deserializer: receive end of the LSB-first serial
//   link driven by our parallel-to-serial shifter. Collects DATA_WIDTH bits
//   qualified by din_en into a word. Presents each completed word on a
//   valid/ready output with a one-word holding register. Flags words lost to
//   back-pressure.
// PARAMETERS
//   DATA_WIDTH  16  bits per word; legal range 2..64
// PORTS
//   clk         in   1           single clock; all logic on posedge
//   reset       in   1           synchronous, active-high reset
//   din         in   1           serial data bit, LSB of word first
//   din_en      in   1           din carries a valid bit this cycle
//   clear       in   1           sync abort of partially received word
//   dout        out  DATA_WIDTH  completed word (holding register)
//   dout_valid  out  1           dout holds an unconsumed word
//   dout_ready  in   1           consumer accepts dout this cycle
//   overflow    out  1           sticky: a completed word was dropped
//   busy        out  1           partial word in progress (bit_cnt != 0)
// BEHAVIOUR
//   Reset (sampled on posedge while reset=1): shift_reg='0, bit_cnt=0,
//     dout='0, dout_valid=0, overflow=0, busy=0. Reset overrides all inputs,
//     including mid-word and with dout_valid high; the partial and held words
//     are discarded.
//   Shift: on din_en, shift_reg <= {din, shift_reg[DATA_WIDTH-1:1]}, so the
//     first received bit ends in bit 0. bit_cnt increments by 1. When
//     bit_cnt==DATA_WIDTH-1, bit_cnt wraps to 0 and the word completes.
//   Completed word = {din, shift_reg[DATA_WIDTH-1:1]} (includes current bit).
//   Latency: dout_valid rises on the edge that samples the last bit.
//     A back-to-back stream yields one word every DATA_WIDTH cycles.
//   Output handshake: a transfer occurs when dout_valid & dout_ready.
//     dout is stable while dout_valid=1 and no transfer has occurred.
//     dout_valid does not depend combinationally on dout_ready.
//   Holding register, per posedge:
//     complete & (!dout_valid | dout_ready): load word, dout_valid=1.
//     complete & dout_valid & !dout_ready: drop word, set overflow;
//       dout and dout_valid unchanged.
//     !complete & transfer: dout_valid=0; dout keeps its last value.
//   overflow stays set until reset; there is no other clear.
//   clear: bit_cnt=0 and shift_reg='0. clear wins over a same-cycle din_en;
//     that bit is discarded and no word completes. The holding register,
//     dout_valid and overflow are unaffected.
//   din_en=0: the shift register and counter hold; gaps between bits are
//     allowed.
//   busy = (bit_cnt != 0), registered state only.
// STRUCTURE
//   Package sipo_pkg: function cnt_w(w) = $clog2(w). bit_cnt is cnt_w(DATA_WIDTH)
//     bits wide, compared against DATA_WIDTH-1 at the same width.
//   Sub-module sipo_hold_reg: one-entry valid/ready register with a
//     drop/overflow output. The top level holds the shifter and counter only.
//   No latches, no async logic, no multi-cycle paths.
// TESTING (DATA_WIDTH=16)
//   1 Reset, then 16 contiguous din_en bits of 16'hA5C3, LSB first, with
//     dout_ready=1 -> dout=16'hA5C3 and dout_valid=1 on the 16th edge for one
//     cycle; busy high for 15 cycles; overflow=0.
//   2 Same word with random 0-3 cycle din_en gaps -> identical dout=16'hA5C3;
//     counter holds during gaps.
//   3 dout_ready=0; send 16'h1234, then 16'hFFFF -> dout stays 16'h1234,
//     overflow=1; with dout_ready=1 next, one transfer, then dout_valid=0.
//   4 Word 16'h00FF held, dout_ready=1 on the cycle 16'hBEEF completes
//     -> 16'h00FF transfers, dout=16'hBEEF, dout_valid stays 1, no overflow.
//   5 8 bits sent, then clear together with din_en, then 16 bits of
//     16'h5A5A -> dout=16'h5A5A, busy=0 right after clear.
//   6 Reset asserted after 5 bits with dout_valid=1 -> all outputs 0 on the
//     next edge; next 16 bits form a clean word.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared sizing helpers for the serial-in, parallel-out deserializer.
package sipo_pkg;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register; a word arriving while full and not
// draining is dropped and recorded in a sticky overflow flag.
module sipo_hold_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (in_valid_i && (!valid_q || out_ready_i)) begin
      data_d  = in_data_i;
      valid_d = 1'b1;
    end else if (in_valid_i) begin
      ovf_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel deserializer: shifter and bit counter feeding a
// one-word valid/ready holding register.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  din_en,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow,
  output logic                  busy
);

  localparam int              CW   = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  complete;

  assign word = {din, shift_q[DATA_WIDTH-1:1]};

  // clear has priority so a bit arriving with it never completes a word
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (din_en) begin
      shift_d = word;
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

  sipo_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .in_data_i   (word),
    .in_valid_i  (complete),
    .out_data_o  (dout),
    .out_valid_o (dout_valid),
    .out_ready_i (dout_ready),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed scenarios plus random traffic against a
// bit-counting reference model of word assembly and the one-word output buffer.
module tb_sipo_deser;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         din = 1'b0;
  logic         din_en = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overflow;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // reference model state
  int          m_nbits = 0;
  longint      m_acc   = 0;
  logic [W-1:0] m_dout = '0;
  logic        m_valid = 1'b0;
  logic        m_ovf   = 1'b0;

  sipo_deser #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_en     (din_en),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model by the same rules, compare all outputs.
  task automatic cycle(input logic b, input logic en, input logic clr,
                       input logic rdy, input logic rst);
    logic         done;
    logic [W-1:0] word;
    din = b; din_en = en; clear = clr; dout_ready = rdy; reset = rst;
    @(posedge clk);
    #1;
    done = 1'b0;
    word = '0;
    if (rst) begin
      m_nbits = 0; m_acc = 0; m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      if (clr) begin
        m_nbits = 0; m_acc = 0;
      end else if (en) begin
        m_acc = m_acc + (longint'(b) << m_nbits);
        m_nbits++;
        if (m_nbits == W) begin
          done = 1'b1; word = W'(m_acc); m_nbits = 0; m_acc = 0;
        end
      end
      if (done && (!m_valid || rdy)) begin
        m_dout = word; m_valid = 1'b1;
      end else if (done) begin
        m_ovf = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    chk("dout", 64'(dout), 64'(m_dout));
    chk("dout_valid", 64'(dout_valid), 64'(m_valid));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("busy", 64'(busy), 64'(m_nbits != 0));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'($urandom), 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Send the low n bits of w LSB first, random 0..maxgap idle cycles before each.
  task automatic send_bits(input logic [63:0] w, input int n, input int maxgap,
                           input logic rdy_body, input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap), rdy_body);
      cycle(w[i], 1'b1, 1'b0, (i == n - 1) ? rdy_last : rdy_body, 1'b0);
    end
  endtask

  initial begin
    int busy_cnt;
    // 1: reset state, contiguous word
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_valid", 64'(dout_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      cycle(W'(16'hA5C3) >> i, 1'b1, 1'b0, 1'b1, 1'b0);
      if (busy) busy_cnt++;
    end
    chk("t1_dout", 64'(dout), 64'hA5C3);
    chk("t1_valid", 64'(dout_valid), 64'h1);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd15);
    idle(1, 1'b1);
    chk("t1_valid_one_cycle", 64'(dout_valid), 64'h0);

    // 2: same word with gaps
    send_bits(64'hA5C3, W, 3, 1'b1, 1'b1);
    chk("t2_dout", 64'(dout), 64'hA5C3);
    idle(2, 1'b1);

    // 3: back-pressure and overflow
    send_bits(64'h1234, W, 0, 1'b0, 1'b0);
    send_bits(64'hFFFF, W, 1, 1'b0, 1'b0);
    chk("t3_dout", 64'(dout), 64'h1234);
    chk("t3_ovf", 64'(overflow), 64'h1);
    idle(1, 1'b1);
    chk("t3_drained", 64'(dout_valid), 64'h0);
    idle(2, 1'b0);

    // 4: transfer and load on the same edge
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(64'h00FF, W, 0, 1'b0, 1'b0);
    send_bits(64'hBEEF, W, 2, 1'b0, 1'b1);
    chk("t4_dout", 64'(dout), 64'hBEEF);
    chk("t4_valid", 64'(dout_valid), 64'h1);
    chk("t4_ovf", 64'(overflow), 64'h0);
    idle(1, 1'b1);

    // 5: clear mid-word, with a same-cycle din_en
    send_bits(64'hFF, 8, 0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_busy_after_clear", 64'(busy), 64'h0);
    send_bits(64'h5A5A, W, 0, 1'b0, 1'b0);
    chk("t5_dout", 64'(dout), 64'h5A5A);

    // 6: reset mid-word with a held word
    send_bits(64'h0005, 5, 0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_dout", 64'(dout), 64'h0);
    chk("t6_valid", 64'(dout_valid), 64'h0);
    chk("t6_busy", 64'(busy), 64'h0);
    send_bits(64'h3C96, W, 0, 1'b0, 1'b0);
    chk("t6_clean", 64'(dout), 64'h3C96);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
            1'($urandom), ($urandom_range(0, 150) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
